// File: rtl/aud_pkg.sv
// Shared audio-path types: receiver FSM states, channel tags and the sample
// record exchanged with the DAC serializer.
package aud_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    SKIP,
    SHIFT,
    PUSH,
    WAIT
  } aud_rx_state_e;

  localparam logic LEFT  = 1'b0;
  localparam logic RIGHT = 1'b1;

  typedef struct packed {
    logic        right;
    logic [15:0] data;
  } aud_sample_t;

endpackage

// File: rtl/aud_fifo2.sv
// Two-entry valid/ready FIFO with flush. A push into a full FIFO succeeds only
// when a pop frees a slot in the same cycle.
module aud_fifo2 #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic       do_push;
  logic       do_pop;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_slot
      logic [W-1:0] slot;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          slot <= '0;
        else if (flush)
          slot <= '0;
        else if (do_push && (wr_ptr == 1'(gi)))
          slot <= wdata;
      end
    end
  endgenerate

  assign rdata = rd_ptr ? g_slot[1].slot : g_slot[0].slot;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/aud_i2s_rx.sv
// WM8731 ADC serial receiver: synchronizes BCLK/LRCK/DATA into i_clk, frames
// words on BCLK rising edges and queues {channel, word} in a 2-entry FIFO.
module aud_i2s_rx
  import aud_pkg::*;
#(
  parameter int         WIDTH   = 16,
  parameter int         DELAY   = 1,
  parameter logic [1:0] CH_MASK = 2'b11
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_AUD_BCLK,
  input  logic             i_AUD_ADCLRCK,
  input  logic             i_AUD_ADCDAT,
  output logic [WIDTH-1:0] o_data,
  output logic             o_right,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_overrun,
  output logic             o_frame_err
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int SW = (DELAY > 1) ? $clog2(DELAY) : 1;
  localparam logic [SW-1:0] SKIP_INIT = (DELAY > 1) ? SW'(DELAY - 1) : '0;

  logic [1:0]       bclk_sync;
  logic [1:0]       lrck_sync;
  logic [2:0]       dat_sync;
  logic             bclk_d;
  logic             rise;
  logic             lrck;
  logic             dat;
  logic             lrck_prev;
  logic             lrck_seen;
  logic             change;
  aud_rx_state_e    state;
  logic             channel;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic [SW-1:0]    skip_cnt;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  logic [WIDTH:0]   head;

  // Data carries one extra stage so it lines up with the edge-detect flop.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bclk_sync <= '0;
      lrck_sync <= '0;
      dat_sync  <= '0;
      bclk_d    <= 1'b0;
    end else begin
      bclk_sync <= {bclk_sync[0], i_AUD_BCLK};
      lrck_sync <= {lrck_sync[0], i_AUD_ADCLRCK};
      dat_sync  <= {dat_sync[1:0], i_AUD_ADCDAT};
      bclk_d    <= bclk_sync[1];
    end
  end

  assign rise = bclk_sync[1] & ~bclk_d;
  assign lrck = lrck_sync[1];
  assign dat  = dat_sync[2];

  // No change is reported until one LRCK level has been observed, so starting
  // mid-channel never fakes a frame boundary.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lrck_prev <= LEFT;
      lrck_seen <= 1'b0;
    end else if (rise) begin
      lrck_prev <= lrck;
      lrck_seen <= 1'b1;
    end
  end

  assign change = rise && lrck_seen && (lrck != lrck_prev);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      channel     <= LEFT;
      shreg       <= '0;
      cnt         <= '0;
      skip_cnt    <= '0;
      o_frame_err <= 1'b0;
    end else if (!i_en) begin
      state       <= IDLE;
      shreg       <= '0;
      cnt         <= '0;
      skip_cnt    <= '0;
      o_frame_err <= 1'b0;
    end else if (change && (state inside {SYNC, SKIP, SHIFT, WAIT})) begin
      channel <= lrck;
      if (state == SKIP || state == SHIFT) o_frame_err <= 1'b1;
      if (DELAY > 0) begin
        state    <= SKIP;
        skip_cnt <= SKIP_INIT;
        cnt      <= '0;
      end else begin
        state <= SHIFT;
        shreg <= WIDTH'(dat);
        cnt   <= CW'(1);
      end
    end else begin
      case (state)
        IDLE: state <= SYNC;
        SKIP: begin
          if (skip_cnt == '0)
            state <= SHIFT;
          else if (rise)
            skip_cnt <= skip_cnt - SW'(1);
        end
        SHIFT: begin
          if (rise) begin
            shreg <= {shreg[WIDTH-2:0], dat};
            cnt   <= cnt + CW'(1);
            if (cnt == CW'(WIDTH - 1)) state <= PUSH;
          end
        end
        PUSH:    state <= WAIT;
        default: ;
      endcase
    end
  end

  assign push = (state == PUSH) && CH_MASK[channel];
  assign pop  = o_valid && i_ready;

  aud_fifo2 #(
    .W(WIDTH + 1)
  ) u_fifo (
    .clk  (i_clk),
    .rst_n(i_rst_n),
    .flush(!i_en),
    .push (push),
    .wdata({channel, shreg}),
    .pop  (pop),
    .rdata(head),
    .full (full),
    .empty(empty)
  );

  assign o_valid = !empty;
  assign o_right = head[WIDTH];
  assign o_data  = head[WIDTH-1:0];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      o_overrun <= 1'b0;
    else if (!i_en)
      o_overrun <= 1'b0;
    else if (push && full && !pop)
      o_overrun <= 1'b1;
  end

endmodule

// File: tb/tb_aud_i2s_rx.sv
// Directed bench: three receivers (I2S, left-justified, left-only) share one
// codec stimulus; received words are collected per instance and compared.
module tb_aud_i2s_rx;

  logic clk = 1'b0;
  logic rst_n, en, bclk, lrck, dat, ready;
  logic [15:0] d1, d0, dm;
  logic r1, r0, rm, v1, v0, vm, ov1, ov0, ovm, fe1, fe0, fem;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int lsb_cyc = 0;
  int rise_cyc = 0;
  logic v1_prev = 1'b0;
  logic [16:0] q1[$];
  logic [16:0] q0[$];
  logic [16:0] qm[$];

  typedef struct {
    logic        ch;
    logic [15:0] word;
    logic        lj;
    int          nslots;
    logic        e1v;
    logic [15:0] e1;
    logic        e0v;
    logic [15:0] e0;
    logic        emv;
  } vec_t;
  vec_t vecs[10];

  always #5 clk = ~clk;

  aud_i2s_rx #(.WIDTH(16), .DELAY(1), .CH_MASK(2'b11)) dut_i2s (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_AUD_BCLK(bclk), .i_AUD_ADCLRCK(lrck),
    .i_AUD_ADCDAT(dat), .o_data(d1), .o_right(r1), .o_valid(v1), .i_ready(ready),
    .o_overrun(ov1), .o_frame_err(fe1));

  aud_i2s_rx #(.WIDTH(16), .DELAY(0), .CH_MASK(2'b11)) dut_lj (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_AUD_BCLK(bclk), .i_AUD_ADCLRCK(lrck),
    .i_AUD_ADCDAT(dat), .o_data(d0), .o_right(r0), .o_valid(v0), .i_ready(ready),
    .o_overrun(ov0), .o_frame_err(fe0));

  aud_i2s_rx #(.WIDTH(16), .DELAY(1), .CH_MASK(2'b01)) dut_left (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_AUD_BCLK(bclk), .i_AUD_ADCLRCK(lrck),
    .i_AUD_ADCDAT(dat), .o_data(dm), .o_right(rm), .o_valid(vm), .i_ready(ready),
    .o_overrun(ovm), .o_frame_err(fem));

  always @(posedge clk) cyc <= cyc + 1;

  // Handshakes are recorded on the falling edge, with the same valid/ready the
  // DUT sees at the next rising edge.
  always @(negedge clk) begin
    if (rst_n && ready) begin
      if (v1) q1.push_back({r1, d1});
      if (v0) q0.push_back({r0, d0});
      if (vm) qm.push_back({rm, dm});
    end
    if (v1 && !v1_prev) rise_cyc <= cyc;
    v1_prev <= v1;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic pop_chk(input string name, input int which, input logic ev,
                         input logic [16:0] exp, input int extra);
    int n;
    logic [16:0] got;
    got = '0;
    n = (which == 0) ? q1.size() : (which == 1) ? q0.size() : qm.size();
    if (ev) begin
      checks++;
      if (n == 0) begin
        failures++;
        $display("FAIL %s: got no word expected %h", name, exp);
      end else begin
        case (which)
          0:       got = q1.pop_front();
          1:       got = q0.pop_front();
          default: got = qm.pop_front();
        endcase
        n--;
        if (got !== exp) begin
          failures++;
          $display("FAIL %s: got %h expected %h", name, got, exp);
        end
      end
    end
    checks++;
    if (n != extra) begin
      failures++;
      $display("FAIL %s_count: got %0d queued expected %0d", name, n, extra);
    end
  endtask

  // One LRCK half-period: data and LRCK change on the BCLK falling edge,
  // BCLK = clk/8. I2S puts the MSB in slot 1, left-justified in slot 0.
  task automatic send_half(input logic ch, input logic [15:0] w, input logic lj, input int nslots);
    for (int s = 0; s < nslots; s++) begin
      bclk = 1'b0;
      if (s == 0) lrck = ch;
      if (lj) dat = (s < 16) ? w[4'(15 - s)] : 1'b0;
      else    dat = (s >= 1 && s <= 16) ? w[4'(16 - s)] : 1'b0;
      repeat (4) @(posedge clk);
      #1;
      bclk = 1'b1;
      if (!lj && s == 16) lsb_cyc = cyc;
      repeat (4) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    vecs[0] = '{1'b0, 16'h8001, 1'b0, 20, 1'b1, 16'h8001, 1'b1, 16'h4000, 1'b1};
    vecs[1] = '{1'b1, 16'h7FFE, 1'b0, 20, 1'b1, 16'h7FFE, 1'b1, 16'h3FFF, 1'b0};
    vecs[2] = '{1'b0, 16'h8001, 1'b1, 20, 1'b1, 16'h0002, 1'b1, 16'h8001, 1'b1};
    vecs[3] = '{1'b1, 16'h7FFE, 1'b1, 20, 1'b1, 16'hFFFC, 1'b1, 16'h7FFE, 1'b0};
    vecs[4] = '{1'b0, 16'h1357, 1'b0, 10, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0};
    vecs[5] = '{1'b1, 16'h1234, 1'b0, 20, 1'b1, 16'h1234, 1'b1, 16'h091A, 1'b0};
    vecs[6] = '{1'b0, 16'hA5A5, 1'b0, 20, 1'b1, 16'hA5A5, 1'b1, 16'h52D2, 1'b1};
    vecs[7] = '{1'b1, 16'h5A5A, 1'b0, 20, 1'b1, 16'h5A5A, 1'b1, 16'h2D2D, 1'b0};
    vecs[8] = '{1'b0, 16'hFFFF, 1'b0, 20, 1'b1, 16'hFFFF, 1'b1, 16'h7FFF, 1'b1};
    vecs[9] = '{1'b1, 16'h0000, 1'b0, 20, 1'b1, 16'h0000, 1'b1, 16'h0000, 1'b0};

    rst_n = 1'b0; en = 1'b0; ready = 1'b1; bclk = 1'b0; lrck = 1'b1; dat = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data", 32'(d1), 32'h0);
    check("rst_right", 32'(r1), 32'h0);
    check("rst_valid", 32'(v1), 32'h0);
    check("rst_overrun", 32'(ov1), 32'h0);
    check("rst_frame_err", 32'(fe1), 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_half(1'b1, 16'h0000, 1'b0, 4);
    en = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 10; i++) begin
      send_half(vecs[i].ch, vecs[i].word, vecs[i].lj, vecs[i].nslots);
      pop_chk($sformatf("v%0d_i2s", i), 0, vecs[i].e1v, {vecs[i].ch, vecs[i].e1}, 0);
      pop_chk($sformatf("v%0d_lj", i), 1, vecs[i].e0v, {vecs[i].ch, vecs[i].e0}, 0);
      pop_chk($sformatf("v%0d_left", i), 2, vecs[i].emv, {vecs[i].ch, vecs[i].e1}, 0);
      if (i == 0) check("latency", 32'(rise_cyc - lsb_cyc), 32'd4);
      if (i == 3) begin
        check("clean_overrun", 32'(ov1), 32'h0);
        check("clean_frame_err", 32'(fe1), 32'h0);
      end
    end
    check("frame_err_i2s", 32'(fe1), 32'h1);
    check("frame_err_lj", 32'(fe0), 32'h1);
    check("no_overrun", 32'(ov1), 32'h0);

    // Three words into a 2-entry FIFO with the consumer stalled.
    ready = 1'b0;
    send_half(1'b0, 16'h1111, 1'b0, 20);
    send_half(1'b1, 16'h2222, 1'b0, 20);
    send_half(1'b0, 16'h3333, 1'b0, 20);
    check("ovr_valid", 32'(v1), 32'h1);
    check("ovr_head", 32'({r1, d1}), 32'h01111);
    check("ovr_flag", 32'(ov1), 32'h1);
    ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    pop_chk("ovr_w0", 0, 1'b1, {1'b0, 16'h1111}, 1);
    pop_chk("ovr_w1", 0, 1'b1, {1'b1, 16'h2222}, 0);
    check("ovr_sticky", 32'(ov1), 32'h1);
    q0.delete();
    qm.delete();

    // Asynchronous reset in the middle of a right word.
    send_half(1'b1, 16'h9999, 1'b0, 9);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_data", 32'(d1), 32'h0);
    check("arst_right", 32'(r1), 32'h0);
    check("arst_valid", 32'(v1), 32'h0);
    check("arst_overrun", 32'(ov1), 32'h0);
    check("arst_frame_err", 32'(fe1), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_half(1'b1, 16'h0000, 1'b0, 11);
    send_half(1'b0, 16'hC3C3, 1'b0, 20);
    pop_chk("arst_recover", 0, 1'b1, {1'b0, 16'hC3C3}, 0);
    check("arst_recover_err", 32'(fe1), 32'h0);

    // Enable drop with a buffered word and a pending frame error.
    ready = 1'b0;
    send_half(1'b1, 16'hABCD, 1'b0, 20);
    send_half(1'b0, 16'h4444, 1'b0, 9);
    send_half(1'b1, 16'h5555, 1'b0, 9);
    check("en_pre_err", 32'(fe1), 32'h1);
    check("en_pre_head", 32'({v1, r1, d1}), 32'h3ABCD);
    en = 1'b0;
    @(posedge clk);
    #1;
    check("en_drop_valid", 32'(v1), 32'h0);
    check("en_drop_data", 32'({r1, d1}), 32'h0);
    check("en_drop_err", 32'(fe1), 32'h0);
    check("en_drop_overrun", 32'(ov1), 32'h0);
    ready = 1'b1;
    en = 1'b1;
    send_half(1'b1, 16'h0000, 1'b0, 11);
    send_half(1'b0, 16'h0F0F, 1'b0, 20);
    pop_chk("en_recover", 0, 1'b1, {1'b0, 16'h0F0F}, 0);
    check("en_recover_err", 32'(fe1), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
